// File: rtl/fir_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_rx_pkg
// Purpose  : Shared constants and helpers for the FIR receive buffer:
//            default sample width and depth, MISR polynomial, and the
//            pointer-width helper used to size pointers and the occupancy
//            count.
// Revision : 1.0 - initial release
// ============================================================================
package fir_rx_pkg;

    localparam int          FIR_RX_W_DEFAULT     = 14;
    localparam int          FIR_RX_DEPTH_DEFAULT = 8;
    localparam logic [13:0] FIR_RX_POLY          = 14'h2B09;

    // Number of address bits needed to index 'depth' entries (ceil(log2)).
    function automatic int fir_rx_ptr_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_rx_misr.sv
`default_nettype none
// ============================================================================
// Module   : fir_rx_misr
// Purpose  : W-bit multiple-input signature register. On each enabled edge
//            the signature rotates left by one, folds in the new sample and,
//            when the bit rotated out was set, XORs in the package polynomial.
// Config   : the module body exists only when FIR_RX_SIG_EN is defined, so a
//            build without the signature feature carries no trace of it.
// Ports    : CLK  - clock, rising edge
//            RST  - asynchronous active-high reset, clears signature
//            EN   - update strobe (one accepted sample)
//            DIN  - sample folded into the signature
//            SIG  - current signature
// Revision : 1.0 - initial release
// ============================================================================
`ifdef FIR_RX_SIG_EN
module fir_rx_misr
    import fir_rx_pkg::*;
#(
    parameter int W = FIR_RX_W_DEFAULT
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] DIN,
    output logic [W-1:0] SIG
);

    localparam logic [W-1:0] POLY = W'(FIR_RX_POLY);

    logic [W-1:0] sig_reg;
    logic [W-1:0] sig_next;

    always_comb begin
        sig_next = {sig_reg[W-2:0], sig_reg[W-1]} ^ DIN;
        if (sig_reg[W-1]) begin
            sig_next = sig_next ^ POLY;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sig_reg <= '0;
        end else if (EN) begin
            sig_reg <= sig_next;
        end
    end

    assign SIG = sig_reg;

endmodule
`endif
`default_nettype wire

// File: rtl/fir_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fir_rx_buffer
// Purpose  : First-word-fall-through FIFO behind a FIR filter output. The
//            upstream has no backpressure, so samples arriving while full
//            (and not simultaneously draining) are dropped and a sticky
//            overflow flag is raised. Also counts accepted samples
//            (saturating) and optionally keeps a running MISR signature.
// Config   : FIR_RX_SIG_EN - when defined, SIG is the MISR of accepted
//            samples; otherwise SIG is tied to zero.
// Ports    : CLK   - clock, rising edge
//            RST   - asynchronous active-high reset
//            DIN   - sample in (two's complement), VIN - sample valid
//            DOUT  - head-of-FIFO sample, VOUT - DOUT valid
//            RDY   - downstream ready (pop on VOUT & RDY)
//            COUNT - occupancy 0..DEPTH, FULL - COUNT == DEPTH
//            OVF   - sticky overflow, NSAMP - accepted-sample counter
//            SIG   - sample signature
// Revision : 1.0 - initial release
// ============================================================================
module fir_rx_buffer
    import fir_rx_pkg::*;
#(
    parameter int W     = FIR_RX_W_DEFAULT,
    parameter int DEPTH = FIR_RX_DEPTH_DEFAULT
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [W-1:0]                  DIN,
    input  logic                          VIN,
    output logic [W-1:0]                  DOUT,
    output logic                          VOUT,
    input  logic                          RDY,
    output logic [fir_rx_ptr_w(DEPTH):0]  COUNT,
    output logic                          FULL,
    output logic                          OVF,
    output logic [15:0]                   NSAMP,
    output logic [W-1:0]                  SIG
);

    localparam int            PW      = fir_rx_ptr_w(DEPTH);
    localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          ovf;
    logic [15:0]   nsamp;

    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    // A pop in the same cycle frees the slot a full FIFO needs, so a full
    // FIFO still accepts when the consumer is draining.
    always_comb begin
        full = (count == CNT_MAX);
        pop  = (count != '0) && RDY;
        push = VIN && (!full || pop);
        drop = VIN && full && !pop;
    end

    // DEPTH is a power of two, so plain PW-bit increment wraps modulo DEPTH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            nsamp  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
            if (push && (nsamp != 16'hFFFF)) begin
                nsamp <= nsamp + 16'd1;
            end
        end
    end

    // Storage has no reset: after reset COUNT is zero, so whatever the array
    // holds is never presented as valid. A write while RST is high is
    // harmless for the same reason. When full with a simultaneous pop the
    // write lands on the slot being read; the read is combinational, so the
    // outgoing word is consumed before it is replaced.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= DIN;
        end
    end

    assign DOUT  = mem[rd_ptr];
    assign VOUT  = (count != '0);
    assign COUNT = count;
    assign FULL  = full;
    assign OVF   = ovf;
    assign NSAMP = nsamp;

`ifdef FIR_RX_SIG_EN
    fir_rx_misr #(
        .W (W)
    ) u_misr (
        .CLK (CLK),
        .RST (RST),
        .EN  (push),
        .DIN (DIN),
        .SIG (SIG)
    );
`else
    assign SIG = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_rx_buffer
// Purpose  : Self-checking bench for fir_rx_buffer: a hand-computed vector
//            table, directed corner-case sequences and a randomized run,
//            all compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_rx_buffer;
    import fir_rx_pkg::*;

    localparam int W     = 14;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  DIN = '0;
    logic          VIN = 1'b0;
    logic          RDY = 1'b0;
    logic [W-1:0]  DOUT;
    logic          VOUT;
    logic [CW-1:0] COUNT;
    logic          FULL;
    logic          OVF;
    logic [15:0]   NSAMP;
    logic [W-1:0]  SIG;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    bit           m_ovf;
    int           m_nsamp;
    logic [W-1:0] m_sig;

    fir_rx_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .DIN   (DIN),
        .VIN   (VIN),
        .DOUT  (DOUT),
        .VOUT  (VOUT),
        .RDY   (RDY),
        .COUNT (COUNT),
        .FULL  (FULL),
        .OVF   (OVF),
        .NSAMP (NSAMP),
        .SIG   (SIG)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] sig_upd(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = ((s << 1) | (s >> (W - 1))) ^ d;
        if (s[W-1]) r = r ^ W'(FIR_RX_POLY);
        return r;
    endfunction

    // One clock of the reference model, using the inputs present at the edge.
    task automatic model_edge();
        bit pop, push;
        pop  = (mq.size() != 0) && RDY;
        push = VIN && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(DIN);
            if (m_nsamp < 65535) m_nsamp++;
`ifdef FIR_RX_SIG_EN
            m_sig = sig_upd(m_sig, DIN);
`endif
        end
        if (VIN && !push) m_ovf = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".vout"}, 32'(VOUT), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".dout"}, 32'(DOUT), 32'(mq[0]));
        chk({tag, ".count"}, 32'(COUNT), 32'(mq.size()));
        chk({tag, ".full"},  32'(FULL),  32'(mq.size() == DEPTH));
        chk({tag, ".ovf"},   32'(OVF),   32'(m_ovf));
        chk({tag, ".nsamp"}, 32'(NSAMP), 32'(m_nsamp));
        chk({tag, ".sig"},   32'(SIG),   32'(m_sig));
    endtask

    // Drive inputs, take one edge, sample 1 ns later and compare to model.
    task automatic step(input logic vin, input logic [W-1:0] din, input logic rdy, input string tag);
        VIN = vin; DIN = din; RDY = rdy;
        @(posedge CLK);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        RST = 1'b1; VIN = 1'b0; RDY = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_nsamp = 0; m_sig = '0;
        @(posedge CLK);
        #1;
        check_model("reset");
        @(posedge CLK);
        #3;
        RST = 1'b0;
    endtask

    typedef struct {
        logic         vin;
        logic [W-1:0] din;
        logic         rdy;
        logic         e_vout;
        logic [W-1:0] e_dout;
        int           e_count;
        logic         e_ovf;
        int           e_nsamp;
    } vec_t;

    vec_t vt[6];

    initial begin
        // Hand-computed vectors, applied from reset.
        vt[0] = '{1'b1, 14'h0005, 1'b0, 1'b1, 14'h0005, 1, 1'b0, 1};
        vt[1] = '{1'b1, 14'h0006, 1'b0, 1'b1, 14'h0005, 2, 1'b0, 2};
        vt[2] = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0006, 1, 1'b0, 2};
        vt[3] = '{1'b1, 14'h0007, 1'b1, 1'b1, 14'h0007, 1, 1'b0, 3};
        vt[4] = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0000, 0, 1'b0, 3};
        vt[5] = '{1'b0, 14'h0000, 1'b1, 1'b0, 14'h0000, 0, 1'b0, 3};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            VIN = vt[i].vin; DIN = vt[i].din; RDY = vt[i].rdy;
            @(posedge CLK);
            model_edge();
            #1;
            chk($sformatf("vec%0d.vout", i), 32'(VOUT), 32'(vt[i].e_vout));
            if (vt[i].e_vout) chk($sformatf("vec%0d.dout", i), 32'(DOUT), 32'(vt[i].e_dout));
            chk($sformatf("vec%0d.count", i), 32'(COUNT), 32'(vt[i].e_count));
            chk($sformatf("vec%0d.ovf", i),   32'(OVF),   32'(vt[i].e_ovf));
            chk($sformatf("vec%0d.nsamp", i), 32'(NSAMP), 32'(vt[i].e_nsamp));
        end

        // Signature from reset: 1 then 2 -> 0x0001 then 0x0000 when enabled.
        do_reset();
        step(1'b1, 14'h0001, 1'b0, "sig1");
`ifdef FIR_RX_SIG_EN
        chk("sig_after_1", 32'(SIG), 32'h0001);
`else
        chk("sig_after_1", 32'(SIG), 32'h0000);
`endif
        step(1'b1, 14'h0002, 1'b0, "sig2");
        chk("sig_after_2", 32'(SIG), 32'h0000);

        // Fill 1..8, 9th dropped, drain in order.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, "fill");
        step(1'b1, 14'd9, 1'b0, "ovf");
        chk("ovf.full",  32'(FULL),  32'd1);
        chk("ovf.count", 32'(COUNT), 32'd8);
        chk("ovf.ovf",   32'(OVF),   32'd1);
        chk("ovf.nsamp", 32'(NSAMP), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            chk("drain.dout", 32'(DOUT), 32'(i));
            step(1'b0, '0, 1'b1, "drain");
        end
        chk("drain.empty", 32'(VOUT), 32'd0);
        chk("drain.ovf_sticky", 32'(OVF), 32'd1);

        // Full with simultaneous push and pop: no overflow, count holds.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, "fill2");
        chk("pp.head", 32'(DOUT), 32'd1);
        step(1'b1, 14'd9, 1'b1, "pushpop_full");
        chk("pp.ovf",   32'(OVF),   32'd0);
        chk("pp.count", 32'(COUNT), 32'd8);
        for (int i = 2; i <= 9; i++) begin
            chk("pp.order", 32'(DOUT), 32'(i));
            step(1'b0, '0, 1'b1, "pp_drain");
        end

        // Streaming extremes: occupancy stays at most 1, pointers wrap twice.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i % 2 == 0) ? 14'h2000 : 14'h1FFF, 1'b1, "stream");
            chk("stream.count_le1", 32'(COUNT <= 1), 32'd1);
        end

        // RDY held while in-flight data stays unconsumed keeps DOUT stable.
        do_reset();
        step(1'b1, 14'h0123, 1'b0, "hold0");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 14'h3FFF, 1'b0, "hold");
            chk("hold.dout", 32'(DOUT), 32'h0123);
        end

        // Asynchronous reset mid-cycle with COUNT=5 and OVF=1.
        do_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, W'(i), 1'b0, "pre_rst");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "pre_rst_pop");
        chk("pre_rst.count", 32'(COUNT), 32'd5);
        chk("pre_rst.ovf",   32'(OVF),   32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst.vout",  32'(VOUT),  32'd0);
        chk("arst.count", 32'(COUNT), 32'd0);
        chk("arst.ovf",   32'(OVF),   32'd0);
        chk("arst.nsamp", 32'(NSAMP), 32'd0);
        chk("arst.full",  32'(FULL),  32'd0);
        chk("arst.sig",   32'(SIG),   32'd0);
        // Inputs ignored while reset held.
        VIN = 1'b1; DIN = 14'h0AAA; RDY = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_hold.count", 32'(COUNT), 32'd0);
        chk("rst_hold.nsamp", 32'(NSAMP), 32'd0);
        #3;
        RST = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_nsamp = 0; m_sig = '0;
        step(1'b1, 14'h0042, 1'b0, "post_rst");
        chk("post_rst.dout", 32'(DOUT), 32'h0042);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 W'($urandom),
                 ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70)) ? 1'b1 : 1'b0,
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_rx_buffer.md
FIR_RX_BUFFER -- requirements
Module: fir_rx_buffer

Interface
REQ-001 SHALL have parameter W, default 14, meaning sample width (matches FIR DOUT width).
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port DIN  input  W  sample from FIR DOUT, two's complement.
REQ-006 SHALL have port VIN  input  1  DIN valid, driven from FIR VOUT; no backpressure available upstream.
REQ-007 SHALL have port DOUT  output  W  head-of-FIFO sample.
REQ-008 SHALL have port VOUT  output  1  DOUT valid toward downstream consumer.
REQ-009 SHALL have port RDY  input  1  downstream ready; transfer when VOUT and RDY both high at an edge.
REQ-010 SHALL have port COUNT  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port FULL  output  1  high when COUNT equals DEPTH.
REQ-012 SHALL have port OVF  output  1  sticky overflow flag.
REQ-013 SHALL have port NSAMP  output  16  accepted-sample counter.
REQ-014 SHALL have port SIG  output  W  running sample signature (see Configuration).

Function
REQ-015 SHALL push DIN when VIN high at an edge and either FIFO not full or a pop occurs in the same cycle.
REQ-016 SHALL drop DIN and set OVF when VIN high, FIFO full and no same-cycle pop; stored contents unchanged.
REQ-017 SHALL be first-word-fall-through: VOUT equals (COUNT != 0), DOUT shows oldest entry combinationally from storage.
REQ-018 SHALL give latency one cycle: sample pushed at edge k into empty FIFO is on DOUT with VOUT high after edge k.
REQ-019 SHALL pop on VOUT&RDY; RDY while empty SHALL have no effect.
REQ-020 SHALL on simultaneous push and pop keep COUNT unchanged, including when full or when COUNT is 1.
REQ-021 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-022 SHALL increment NSAMP per accepted push, saturating at 16'hFFFF; dropped samples not counted.
REQ-023 SHALL keep OVF high until RST; no other clear.
REQ-024 SHALL keep DOUT stable while VOUT high and RDY low.

Reset
REQ-025 SHALL on RST high, asynchronously: pointers 0, COUNT 0, VOUT 0, FULL 0, OVF 0, NSAMP 0, SIG 0; DOUT value don't-care but VOUT low.
REQ-026 SHALL on RST mid-stream discard all stored samples; first push after RST deasserts is handled as into empty FIFO.
REQ-027 SHALL ignore VIN and RDY while RST high.

Configuration
REQ-028 SHALL, with macro FIR_RX_SIG_EN defined, update SIG on each accepted push as W-bit MISR: SIG <= {SIG[W-2:0], SIG[W-1]} ^ DIN ^ (SIG[W-1] ? POLY : 0), POLY from package.
REQ-029 SHALL, without FIR_RX_SIG_EN, tie SIG to 0 and instantiate no signature logic.

Structure
REQ-030 SHALL place W default, DEPTH default, pointer-width function/constant and MISR POLY (14'h2B09) in shared package fir_rx_pkg.
REQ-031 SHALL implement the signature in sub-module fir_rx_misr, instantiated only under FIR_RX_SIG_EN.
REQ-032 SHALL use storage as plain register array; no vendor RAM macros.

Verification
REQ-033 SHALL cover: reset, VIN=1 DIN=14'h0005 one cycle, RDY=0 -> after edge VOUT=1 DOUT=5 COUNT=1 NSAMP=1.
REQ-034 SHALL cover: 8 pushes 1..8 with RDY=0, then 9th push 9 -> FULL=1 COUNT=8 OVF=1 NSAMP=8; drain with RDY=1 yields 1..8 in order.
REQ-035 SHALL cover: FIFO full, VIN=1 DIN=9 and RDY=1 same cycle -> OVF stays 0, COUNT stays 8, output order 2..9 after 1.
REQ-036 SHALL cover: continuous VIN and RDY for 20 samples (-8192, 8191, alternating) -> COUNT never exceeds 1, outputs bit-exact, pointers wrap twice.
REQ-037 SHALL cover: RST asserted asynchronously mid-cycle with COUNT=5, OVF=1 -> immediately VOUT=0 COUNT=0 OVF=0 NSAMP=0.
REQ-038 SHALL cover: FIR_RX_SIG_EN defined, pushes 14'h0001 then 14'h0002 from reset -> SIG=14'h0001 then 14'h0000; undefined -> SIG=0 throughout.
